// File: rtl/fm_tx_pkg.sv
// Shared constants for the FM transmitter control slice: register map, FSM states, full-scale gain.
package fm_tx_pkg;

    localparam logic [1:0] ADDR_ACC_INC    = 2'd0;
    localparam logic [1:0] ADDR_DEV        = 2'd1;
    localparam logic [1:0] ADDR_SAMPLE_DIV = 2'd2;
    localparam logic [1:0] ADDR_CTRL       = 2'd3;

    localparam logic [3:0] G_FULL = 4'd8;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_MUTE_DOWN = 2'd1,
        ST_RETUNE    = 2'd2,
        ST_MUTE_UP   = 2'd3
    } tx_state_e;

endpackage

// File: rtl/fm_tx_tick_gen.sv
// Audio sample-rate tick: a down-counter that reloads the divider at zero, giving one tick every div+1 cycles.
module fm_tx_tick_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] div,
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    // A divider write restarts the period from the new value.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (load) begin
            cnt  <= load_val;
            tick <= 1'b0;
        end else if (cnt == '0) begin
            cnt  <= div;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt - 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/fm_tx_ctrl.sv
// FM transmitter control: config register file, audio sample gain path, and the mute/retune/unmute FSM.
// Define FM_TX_CTRL_SOFTMUTE_EN for tick-paced gain ramps; otherwise the mute is a hard 3-cycle step.
module fm_tx_ctrl
    import fm_tx_pkg::*;
#(
    parameter int A     = 8,
    parameter int N     = 18,
    parameter int K     = 4,
    parameter int L     = 2,
    parameter int DIV_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [1:0]          cfg_addr,
    input  logic [N-1:0]        cfg_data,
    input  logic signed [A-1:0] audio_in,
    input  logic                audio_valid,
    output logic                audio_req,
    output logic signed [A-1:0] audio,
    output logic [N-1:0]        acc_inc,
    output logic [K-1:0]        df_inc_coef,
    output logic [L-1:0]        df_inc_fact,
    output logic                busy,
    output logic                underrun
);

    tx_state_e           state, state_nxt;
    logic [3:0]          g, g_nxt;
    logic                acc_ld;
    logic [N-1:0]        pending_inc;
    logic [DIV_W-1:0]    sample_div;
    logic                tx_en;
    logic signed [A-1:0] audio_lat;
    logic signed [A+4:0] prod;
    logic                tick;
    logic                wr;

    assign cfg_ready = (state == ST_RUN);
    assign busy      = (state != ST_RUN);
    assign wr        = cfg_valid && cfg_ready;
    assign audio_req = tick;

    fm_tx_tick_gen #(.DIV_W(DIV_W)) u_tick (
        .clk      (clk),
        .rst      (rst),
        .div      (sample_div),
        .load     (wr && cfg_addr == ADDR_SAMPLE_DIV),
        .load_val (cfg_data[DIV_W-1:0]),
        .tick     (tick)
    );

    always_comb begin
        state_nxt = state;
        g_nxt     = g;
        acc_ld    = 1'b0;
        case (state)
            ST_RUN: if (wr && cfg_addr == ADDR_ACC_INC) state_nxt = ST_MUTE_DOWN;
`ifdef FM_TX_CTRL_SOFTMUTE_EN
            ST_MUTE_DOWN: begin
                if (tick && g != '0) g_nxt = g - 4'd1;
                if (g_nxt == '0) state_nxt = ST_RETUNE;
            end
            ST_RETUNE: begin
                acc_ld    = 1'b1;
                state_nxt = ST_MUTE_UP;
            end
            ST_MUTE_UP: begin
                if (g >= G_FULL) state_nxt = ST_RUN;
                else if (tick)   g_nxt = g + 4'd1;
            end
`else
            ST_MUTE_DOWN: begin
                g_nxt     = '0;
                state_nxt = ST_RETUNE;
            end
            ST_RETUNE: begin
                acc_ld    = 1'b1;
                g_nxt     = G_FULL;
                state_nxt = ST_MUTE_UP;
            end
            ST_MUTE_UP: state_nxt = ST_RUN;
`endif
            default: state_nxt = ST_RUN;
        endcase
    end

    // Gain is 0..8, so the product needs 5 extra bits before the divide-by-8.
    assign prod = (A+5)'(audio_lat) * (A+5)'($signed({1'b0, g}));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_RUN;
            g           <= G_FULL;
            acc_inc     <= '0;
            pending_inc <= '0;
            df_inc_coef <= '0;
            df_inc_fact <= '0;
            sample_div  <= '0;
            tx_en       <= 1'b0;
            audio_lat   <= '0;
            audio       <= '0;
            underrun    <= 1'b0;
        end else begin
            state <= state_nxt;
            g     <= g_nxt;
            if (acc_ld) acc_inc <= pending_inc;
            if (wr) begin
                case (cfg_addr)
                    ADDR_ACC_INC: pending_inc <= cfg_data;
                    ADDR_DEV: begin
                        df_inc_coef <= cfg_data[K+L-1:L];
                        df_inc_fact <= cfg_data[L-1:0];
                    end
                    ADDR_SAMPLE_DIV: sample_div <= cfg_data[DIV_W-1:0];
                    default: begin
                        tx_en <= cfg_data[0];
                        if (cfg_data[1]) underrun <= 1'b0;
                    end
                endcase
            end
            // Placed after the clear so a same-cycle missed sample wins.
            if (tick) begin
                if (audio_valid) audio_lat <= audio_in;
                else             underrun  <= 1'b1;
            end
            audio <= tx_en ? A'(prod >>> 3) : '0;
        end
    end

endmodule

// File: tb/tb_fm_tx_ctrl.sv
// Directed bench for fm_tx_ctrl with a cycle model of ticks, gain ramps and registers checked every cycle.
module tb_fm_tx_ctrl;
    localparam int A = 8, N = 18, K = 4, L = 2, DIV_W = 16;
`ifdef FM_TX_CTRL_SOFTMUTE_EN
    localparam int SOFT = 1;
`else
    localparam int SOFT = 0;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                cfg_valid = 1'b0;
    logic                cfg_ready;
    logic [1:0]          cfg_addr = '0;
    logic [N-1:0]        cfg_data = '0;
    logic signed [A-1:0] audio_in = '0;
    logic                audio_valid = 1'b0;
    logic                audio_req;
    logic signed [A-1:0] audio;
    logic [N-1:0]        acc_inc;
    logic [K-1:0]        df_inc_coef;
    logic [L-1:0]        df_inc_fact;
    logic                busy;
    logic                underrun;

    int n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    fm_tx_ctrl #(.A(A), .N(N), .K(K), .L(L), .DIV_W(DIV_W)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .audio_in(audio_in),
        .audio_valid(audio_valid), .audio_req(audio_req), .audio(audio),
        .acc_inc(acc_inc), .df_inc_coef(df_inc_coef), .df_inc_fact(df_inc_fact),
        .busy(busy), .underrun(underrun)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Model: cycles since the last divider load/reset, gain, retune phase (0 idle, 1 down, 2 retune, 3 up).
    int m_n = 0, m_div = 0, m_g = 8, m_mode = 0, m_acc = 0, m_pend = 0;
    int m_coef = 0, m_fact = 0, m_txen = 0, m_lat = 0, m_audio = 0, m_under = 0;
    bit m_ok = 0;

    function automatic bit m_tick();
        return (m_n >= m_div + 2) && ((m_n - 1) % (m_div + 1) == 0);
    endfunction

    task automatic model_step();
        bit tk, w;
        int d;
        tk = m_tick();
        if (rst) begin
            m_ok = 1; m_n = 1; m_div = 0; m_g = 8; m_mode = 0; m_acc = 0; m_pend = 0;
            m_coef = 0; m_fact = 0; m_txen = 0; m_lat = 0; m_audio = 0; m_under = 0;
            return;
        end
        if (!m_ok) return;
        w = cfg_valid && (m_mode == 0);
        d = int'(cfg_data);
        m_audio = (m_txen != 0) ? ((m_lat * m_g) >>> 3) : 0;
        case (m_mode)
            1: if (SOFT != 0) begin
                   if (tk && m_g > 0) m_g--;
                   if (m_g == 0) m_mode = 2;
               end else begin
                   m_g = 0; m_mode = 2;
               end
            2: begin
                   m_acc = m_pend; m_mode = 3;
                   if (SOFT == 0) m_g = 8;
               end
            3: if (SOFT == 0 || m_g == 8) m_mode = 0;
               else if (tk) m_g++;
            default: if (w && cfg_addr == 2'd0) begin m_pend = d; m_mode = 1; end
        endcase
        if (w) begin
            case (cfg_addr)
                2'd1: begin m_coef = (d >> 2) & 15; m_fact = d & 3; end
                2'd2: m_div = d & 16'hFFFF;
                2'd3: begin m_txen = d & 1; if ((d & 2) != 0) m_under = 0; end
                default: ;
            endcase
        end
        if (tk) begin
            if (audio_valid) m_lat = int'(audio_in);
            else             m_under = 1;
        end
        m_n = (w && cfg_addr == 2'd2) ? 1 : m_n + 1;
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (m_ok) begin
            chk("audio", int'(audio), m_audio);
            chk("acc_inc", int'(acc_inc), m_acc);
            chk("df_inc_coef", int'(df_inc_coef), m_coef);
            chk("df_inc_fact", int'(df_inc_fact), m_fact);
            chk("busy", int'(busy), int'(m_mode != 0));
            chk("cfg_ready", int'(cfg_ready), int'(m_mode == 0));
            chk("audio_req", int'(audio_req), int'(m_tick()));
            chk("underrun", int'(underrun), m_under);
        end
    end

    task automatic wr(input logic [1:0] a, input int d);
        int i;
        i = 0;
        while (!cfg_ready && i < 100) begin @(negedge clk); i++; end
        chk("cfg_ready_wait", int'(cfg_ready), 1);
        cfg_addr  = a;
        cfg_data  = d[N-1:0];
        cfg_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_req();
        int i;
        i = 0;
        while (!audio_req && i < 50) begin @(negedge clk); i++; end
        chk("audio_req_seen", int'(audio_req), 1);
    endtask

    task automatic count_busy(input string name, input int exp);
        int cnt, mn;
        bit saw56;
        cnt = 0; mn = 127; saw56 = 0;
        while (busy && cnt < 60) begin
            cnt++;
            if (int'(audio) < mn) mn = int'(audio);
            if (audio == 8'sd56) saw56 = 1;
            @(negedge clk);
        end
        chk(name, cnt, exp);
        if (exp > 10) chk({name, "_min_audio"}, mn, 0);
        if (exp > 10 && audio_in == 8'sd64) chk({name, "_saw56"}, int'(saw56), 1);
    endtask

    initial begin
        int k;
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cfg_ready", int'(cfg_ready), 1);
        chk("rst_acc_inc", int'(acc_inc), 0);
        chk("rst_audio_req", int'(audio_req), 0);
        chk("rst_audio", int'(audio), 0);
        chk("rst_underrun", int'(underrun), 0);
        rst = 1'b0;
        audio_valid = 1'b1;
        audio_in = 8'sd0;
        @(negedge clk);

        wr(2'd1, 'h0D);
        chk("dev_coef", int'(df_inc_coef), 3);
        chk("dev_fact", int'(df_inc_fact), 1);
        chk("dev_busy", int'(busy), 0);
        wr(2'd1, 'h3F);
        chk("dev_coef_max", int'(df_inc_coef), 15);
        chk("dev_fact_max", int'(df_inc_fact), 3);

        // Divider 3: one request every 4 cycles; sample lands on audio two cycles after its tick.
        wr(2'd3, 1);
        wr(2'd2, 3);
        wait_req();
        audio_in = 8'sd100;
        @(negedge clk);
        chk("audio_before_lat", int'(audio), 0);
        @(negedge clk);
        chk("audio_after_tick", int'(audio), 100);
        k = 2;
        while (k < 20) begin @(negedge clk); k++; if (audio_req) break; end
        chk("req_period", k, 4);

        // Missed sample: latch holds, sticky flag until a clearing CTRL write.
        audio_valid = 1'b0;
        audio_in = 8'sd55;
        @(negedge clk);
        chk("underrun_set", int'(underrun), 1);
        audio_valid = 1'b1;
        audio_in = 8'sd100;
        @(negedge clk);
        chk("lat_held", int'(audio), 100);
        repeat (6) @(negedge clk);
        chk("underrun_sticky", int'(underrun), 1);
        wr(2'd3, 3);
        chk("underrun_cleared", int'(underrun), 0);

        // Clear and set on the same edge: set wins.
        wr(2'd2, 0);
        repeat (3) @(negedge clk);
        audio_valid = 1'b0;
        wr(2'd3, 3);
        audio_valid = 1'b1;
        chk("clear_vs_set", int'(underrun), 1);
        wr(2'd3, 3);
        chk("clear_again", int'(underrun), 0);

        // Full retune with a tick every cycle.
        audio_in = 8'sd64;
        repeat (3) @(negedge clk);
        wr(2'd0, 'h1000);
        count_busy("retune_busy", (SOFT != 0) ? 18 : 3);
        chk("retune_acc_inc", int'(acc_inc), 'h1000);
        chk("retune_audio_back", int'(audio), 64);

        // Reset in the middle of a retune discards the pending increment.
        audio_in = -8'sd100;
        repeat (2) @(negedge clk);
        wr(2'd0, 'h2A);
        repeat ((SOFT != 0) ? 4 : 1) @(negedge clk);
        chk("mid_busy", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_acc_inc", int'(acc_inc), 0);
        chk("midrst_cfg_ready", int'(cfg_ready), 1);
        rst = 1'b0;
        @(negedge clk);

        // Negative samples through the ramp (floor rounding), then a small retune.
        wr(2'd3, 1);
        repeat (3) @(negedge clk);
        chk("neg_audio", int'(audio), -100);
        wr(2'd0, 5);
        count_busy("retune5_busy", (SOFT != 0) ? 18 : 3);
        chk("retune5_acc_inc", int'(acc_inc), 5);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
